wb_regfile_stage: RTL and testbench
===================================

Name: wb_regfile_stage

Overview:
- Consumer end of the MEM/WB pipeline register; the write-back stage of the 5-stage MIPS pipeline.
- Decodes the WB-stage instruction and selects the write data: ALU result, extended load data, or PC+8 for link instructions.
- Commits the result to the 32x32 general register file and serves the ID-stage read ports with write-first bypass.
- Exports the WB write (enable, address, data) for forwarding, and counts retired instructions.

Parameters:
CNT_WIDTH  32  width of retired-instruction counter
BYPASS     1   1 = read ports return same-cycle WB write data; 0 = old register value

Ports:
clk          in   1   clock, all state updates on rising edge
reset        in   1   synchronous, active-low reset
InstrW       in   32  instruction in WB
PCplus8W     in   32  PC+8 of instruction in WB
ALUOutW      in   32  ALU result / memory address in WB
movWriteW    in   1   movz/movn condition met
bWriteW      in   1   branch-and-link condition met
ReadDataW    in   32  raw word read from data memory
A1           in   5   read address port 1
A2           in   5   read address port 2
RD1          out  32  read data port 1
RD2          out  32  read data port 2
WEW          out  1   WB write enable (after $0 suppression)
A3W          out  5   WB destination register
WDW          out  32  WB write data
RetireCount  out  CNT_WIDTH  count of retired non-zero instructions

Behaviour:
- Decode, by op = InstrW[31:26] and funct = InstrW[5:0]:
  - op 0, funct in {00,02,03,04,06,07,10,12,20..27,2A,2B}: dest rd, data ALUOutW.
  - op 0, funct 09 (jalr): dest rd, data PCplus8W.
  - op 0, funct 0A/0B (movz/movn): dest rd, data ALUOutW; write only if movWriteW = 1.
  - op 08..0F: dest rt, data ALUOutW.
  - op 23 lw, 20 lb, 24 lbu, 21 lh, 25 lhu: dest rt, data = extended load value.
  - op 03 (jal): dest 31, data PCplus8W.
  - op 01 with rt 10 or 11 (bltzal/bgezal): dest 31, data PCplus8W; write only if bWriteW = 1.
  - Every other encoding: no write.
- Load extension:
  - lw: uses ReadDataW unchanged; ALUOutW[1:0] is ignored.
  - lb/lbu: byte = ReadDataW[8*ALUOutW[1:0] +: 8]; lb sign-extends, lbu zero-extends.
  - lh/lhu: half = ReadDataW[16*ALUOutW[1] +: 16]; lh sign-extends, lhu zero-extends; ALUOutW[0] is ignored.
- WEW = decoded write AND condition AND (A3W != 0). A3W and WDW are always driven; when WEW = 0 their values are don't-care but deterministic.
- Register file write: on posedge, if reset = 1 and WEW = 1, then reg[A3W] <= WDW. Register $0 always reads 0.
- Reads are combinational:
  - If BYPASS = 1, WEW = 1, and A1 == A3W != 0, then RD1 = WDW; otherwise RD1 = reg[A1].
  - RD2 follows the same rule with A2.
- Retire counter: on posedge, if reset = 1 and InstrW != 0, RetireCount increments. It wraps from 2^CNT_WIDTH-1 to 0.
- Reset (reset = 0 at posedge):
  - All 32 registers clear to 0 and RetireCount clears to 0.
  - Reset wins over a simultaneous write or count.
  - A write in progress during a reset cycle is discarded.
- Latency:
  - A written value is visible on the read ports in the same cycle when BYPASS = 1.
  - Otherwise it is visible from the next cycle.
- No stall or handshake input: every cycle is one WB slot. InstrW = 0 (nop, after MEM/WB register reset) produces no write and no count.

Decomposition:
- Shared package mips_defs:
  - Opcode constants (OP_RTYPE, OP_REGIMM, OP_JAL, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_ADDI..OP_LUI).
  - Funct constants.
  - REGIMM rt codes.
  - Write-source enum {WSRC_ALU, WSRC_MEM, WSRC_PC8}.
  - Destination select enum {DST_RD, DST_RT, DST_31}.
- Sub-module: wb_load_ext, a combinational load aligner/extender taking op, ALUOutW[1:0], and ReadDataW.
- Decode and regfile stay in the top module.

Test Plan:
- Reset:
  - Write reg 5 = 0xDEADBEEF via addiu, then drive reset = 0 for one cycle → RD1 at A1 = 5 reads 0 and RetireCount = 0.
  - addiu to rt = 0 with ALUOutW = 0x1234 → WEW = 0 and reg 0 stays 0.
- Loads:
  - ReadDataW = 0x80FF7F01 → lb at ALUOutW[1:0] = 3 gives 0xFFFFFF80.
  - lbu at offset 1 gives 0x0000007F.
  - lh at ALUOutW[1] = 1 gives 0xFFFF80FF.
  - lhu at ALUOutW[1] = 0 gives 0x00007F01.
  - lw gives 0x80FF7F01.
- Link writes:
  - jal with PCplus8W = 0x00003010 → reg 31 = 0x00003010.
  - bgezal with bWriteW = 0 → no write, reg 31 unchanged.
  - bgezal with bWriteW = 1 → reg 31 written.
  - jalr with rd = 7 → reg 7 = PCplus8W.
- Conditional move: movn to rd = 9 with movWriteW = 0 → no write; the same instruction with movWriteW = 1 and ALUOutW = 0x55 → reg 9 = 0x55.
- Bypass:
  - BYPASS = 1, addu to rd = 4 with ALUOutW = 0xA5A5A5A5 and A1 = A2 = 4 in the same cycle → RD1 = RD2 = 0xA5A5A5A5 before the clock edge.
  - With BYPASS = 0 → old value before the edge, new value after it.
- Counter:
  - 10 cycles of non-zero InstrW interleaved with 3 cycles of InstrW = 0 → RetireCount = 10.
  - Preload near the top with CNT_WIDTH = 4 → 15 then one retire gives 0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS encoding constants and write-back select types.
package mips_defs;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MOVZ = 6'h0A;
  localparam logic [5:0] FN_MOVN = 6'h0B;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  typedef enum logic [1:0] {WSRC_ALU, WSRC_MEM, WSRC_PC8} wsrc_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_31} dst_e;

endpackage

// File: rtl/wb_load_ext.sv
// Aligns the addressed byte/half of a loaded word and sign- or zero-extends it.
module wb_load_ext
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addrLo,
  input  logic [31:0] readData,
  output logic [31:0] loadData
);

  function automatic logic [31:0] extByte(input logic [7:0] b, input logic sgn);
    logic signed [7:0] sb;
    sb = $signed(b);
    return sgn ? 32'($signed(sb)) : {24'h0, b};
  endfunction

  function automatic logic [31:0] extHalf(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    sh = $signed(h);
    return sgn ? 32'($signed(sh)) : {16'h0, h};
  endfunction

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = readData[8*addrLo +: 8];
  assign halfSel = readData[16*addrLo[1] +: 16];

  always_comb begin
    loadData = readData;
    case (op)
      OP_LB:   loadData = extByte(byteSel, 1'b1);
      OP_LBU:  loadData = extByte(byteSel, 1'b0);
      OP_LH:   loadData = extHalf(halfSel, 1'b1);
      OP_LHU:  loadData = extHalf(halfSel, 1'b0);
      default: loadData = readData;
    endcase
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// MIPS write-back stage: result select, 32x32 register file with optional
// write-first read bypass, and a retired-instruction counter.
module wb_regfile_stage
  import mips_defs::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrW,
  input  logic [31:0]          PCplus8W,
  input  logic [31:0]          ALUOutW,
  input  logic                 movWriteW,
  input  logic                 bWriteW,
  input  logic [31:0]          ReadDataW,
  input  logic [4:0]           A1,
  input  logic [4:0]           A2,
  output logic [31:0]          RD1,
  output logic [31:0]          RD2,
  output logic                 WEW,
  output logic [4:0]           A3W,
  output logic [31:0]          WDW,
  output logic [CNT_WIDTH-1:0] RetireCount
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        decWrite;
  logic        condOk;
  wsrc_e       wsrc;
  dst_e        dst;
  logic [31:0] loadData;
  logic [31:0] regs [32];

  assign op    = InstrW[31:26];
  assign funct = InstrW[5:0];
  assign rt    = InstrW[20:16];
  assign rd    = InstrW[15:11];

  always_comb begin
    decWrite = 1'b0;
    condOk   = 1'b1;
    wsrc     = WSRC_ALU;
    dst      = DST_RD;
    case (op)
      OP_RTYPE: begin
        dst = DST_RD;
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_MFHI, FN_MFLO, FN_SLT, FN_SLTU: decWrite = 1'b1;
          FN_JALR: begin
            decWrite = 1'b1;
            wsrc     = WSRC_PC8;
          end
          FN_MOVZ, FN_MOVN: begin
            decWrite = 1'b1;
            condOk   = movWriteW;
          end
          default: decWrite = (funct >= FN_ADD) && (funct <= FN_NOR);
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        decWrite = 1'b1;
        dst      = DST_RT;
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        decWrite = 1'b1;
        dst      = DST_RT;
        wsrc     = WSRC_MEM;
      end
      OP_JAL: begin
        decWrite = 1'b1;
        dst      = DST_31;
        wsrc     = WSRC_PC8;
      end
      OP_REGIMM: begin
        decWrite = (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
        condOk   = bWriteW;
        dst      = DST_31;
        wsrc     = WSRC_PC8;
      end
      default: decWrite = 1'b0;
    endcase
  end

  wb_load_ext uLoadExt (
    .op       (op),
    .addrLo   (ALUOutW[1:0]),
    .readData (ReadDataW),
    .loadData (loadData)
  );

  always_comb begin
    case (dst)
      DST_RT:  A3W = rt;
      DST_31:  A3W = 5'd31;
      default: A3W = rd;
    endcase
    case (wsrc)
      WSRC_MEM: WDW = loadData;
      WSRC_PC8: WDW = PCplus8W;
      default:  WDW = ALUOutW;
    endcase
  end

  // $0 is never a legal destination, so a zero A3W also kills the write.
  assign WEW = decWrite && condOk && (A3W != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      RetireCount <= '0;
    end else begin
      if (WEW) regs[A3W] <= WDW;
      if (InstrW != 32'h0) RetireCount <= RetireCount + CNT_WIDTH'(1);
    end
  end

  // WEW already implies A3W != 0, so a $0 read never picks up bypass data.
  always_comb begin
    RD1 = (A1 == 5'd0) ? 32'h0 : regs[A1];
    RD2 = (A2 == 5'd0) ? 32'h0 : regs[A2];
    if (BYPASS && WEW && (A1 == A3W)) RD1 = WDW;
    if (BYPASS && WEW && (A2 == A3W)) RD2 = WDW;
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: a bypassing 32-bit-counter instance and a
// non-bypassing 4-bit-counter instance share stimulus; a negedge monitor scores both.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] InstrW = '0, PCplus8W = '0, ALUOutW = '0, ReadDataW = '0;
  logic        movWriteW = 1'b0, bWriteW = 1'b0;
  logic [4:0]  A1 = '0, A2 = '0;

  logic [31:0] rd1A, rd2A, wdwA, rd1B, rd2B, wdwB;
  logic        wewA, wewB;
  logic [4:0]  a3wA, a3wB;
  logic [31:0] cntA;
  logic [3:0]  cntB;

  always #5 clk = ~clk;

  wb_regfile_stage #(.CNT_WIDTH(32), .BYPASS(1'b1)) dutA (
    .clk(clk), .reset(reset), .InstrW(InstrW), .PCplus8W(PCplus8W), .ALUOutW(ALUOutW),
    .movWriteW(movWriteW), .bWriteW(bWriteW), .ReadDataW(ReadDataW), .A1(A1), .A2(A2),
    .RD1(rd1A), .RD2(rd2A), .WEW(wewA), .A3W(a3wA), .WDW(wdwA), .RetireCount(cntA)
  );

  wb_regfile_stage #(.CNT_WIDTH(4), .BYPASS(1'b0)) dutB (
    .clk(clk), .reset(reset), .InstrW(InstrW), .PCplus8W(PCplus8W), .ALUOutW(ALUOutW),
    .movWriteW(movWriteW), .bWriteW(bWriteW), .ReadDataW(ReadDataW), .A1(A1), .A2(A2),
    .RD1(rd1B), .RD2(rd2B), .WEW(wewB), .A3W(a3wB), .WDW(wdwB), .RetireCount(cntB)
  );

  localparam int S_RD1 = 0, S_RD2 = 1, S_WEW = 2, S_A3W = 3, S_WDW = 4, S_CNT = 5,
                 S_RD1B = 6, S_CNTB = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rdN);
    return {6'h00, 5'd0, 5'd0, rdN, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opN, input logic [4:0] rtN);
    return {opN, 5'd0, rtN, 16'h0};
  endfunction

  function automatic logic [31:0] regimm(input logic [4:0] rtN);
    return {6'h01, 5'd0, rtN, 16'h0};
  endfunction

  localparam logic [31:0] JAL = {6'h03, 26'h0};
  localparam logic [31:0] BEQ = {6'h04, 26'h0};

  task automatic apply(input logic rstN, input logic [31:0] instr, input logic [31:0] pc8,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic mov,
                       input logic bw, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    reset = rstN; InstrW = instr; PCplus8W = pc8; ALUOutW = alu; ReadDataW = rdata;
    movWriteW = mov; bWriteW = bw; A1 = a1; A2 = a2;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    apply(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, a1, a2);
  endtask

  task automatic expect_(input string tag, input int sel, input logic [31:0] exp);
    item_t it;
    it.tag = tag; it.sel = sel; it.exp = exp;
    q.push_back(it);
  endtask

  // Monitor: every expectation pushed during a cycle is scored on that cycle's negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      item_t it;
      logic [31:0] act;
      it = q.pop_front();
      case (it.sel)
        S_RD1:   act = rd1A;
        S_RD2:   act = rd2A;
        S_WEW:   act = {31'h0, wewA};
        S_A3W:   act = {27'h0, a3wA};
        S_WDW:   act = wdwA;
        S_CNT:   act = cntA;
        S_RD1B:  act = rd1B;
        default: act = {28'h0, cntB};
      endcase
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", it.tag, act, it.exp);
      end
    end
  end

  localparam logic [31:0] LDW = 32'h80FF7F01;

  initial begin
    apply(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd5, 5'd5);
    idle(5'd5, 5'd0);
    expect_("reset_rd1", S_RD1, 32'h0);
    expect_("reset_cnt", S_CNT, 32'h0);
    expect_("reset_cntB", S_CNTB, 32'h0);

    apply(1'b1, itype(6'h09, 5'd5), 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("addiu_wew", S_WEW, 32'h1);
    expect_("addiu_a3w", S_A3W, 32'd5);
    expect_("addiu_wdw", S_WDW, 32'hDEADBEEF);
    idle(5'd5, 5'd0);
    expect_("addiu_rd1", S_RD1, 32'hDEADBEEF);
    expect_("addiu_rd1B", S_RD1B, 32'hDEADBEEF);

    // Reset with a simultaneous write: reset must win.
    apply(1'b0, itype(6'h09, 5'd6), 32'h0, 32'h1, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(5'd5, 5'd6);
    expect_("rst_clears_r5", S_RD1, 32'h0);
    expect_("rst_drops_wr", S_RD2, 32'h0);
    expect_("rst_cnt", S_CNT, 32'h0);

    apply(1'b1, itype(6'h09, 5'd0), 32'h0, 32'h1234, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("r0_wew", S_WEW, 32'h0);
    idle(5'd0, 5'd0);
    expect_("r0_rd1", S_RD1, 32'h0);

    apply(1'b1, itype(6'h20, 5'd10), 32'h0, 32'h3, LDW, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("lb_wdw", S_WDW, 32'hFFFFFF80);
    expect_("lb_wew", S_WEW, 32'h1);
    apply(1'b1, itype(6'h24, 5'd10), 32'h0, 32'h1, LDW, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("lbu_wdw", S_WDW, 32'h0000007F);
    apply(1'b1, itype(6'h21, 5'd10), 32'h0, 32'h2, LDW, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("lh_wdw", S_WDW, 32'hFFFF80FF);
    apply(1'b1, itype(6'h25, 5'd10), 32'h0, 32'h1, LDW, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("lhu_wdw", S_WDW, 32'h00007F01);
    apply(1'b1, itype(6'h23, 5'd10), 32'h0, 32'h3, LDW, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("lw_wdw", S_WDW, 32'h80FF7F01);
    idle(5'd10, 5'd0);
    expect_("lw_rd1", S_RD1, 32'h80FF7F01);

    apply(1'b1, JAL, 32'h00003010, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("jal_a3w", S_A3W, 32'd31);
    expect_("jal_wdw", S_WDW, 32'h00003010);
    idle(5'd31, 5'd0);
    expect_("jal_r31", S_RD1, 32'h00003010);
    apply(1'b1, regimm(5'h11), 32'h00004444, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("bgezal0_wew", S_WEW, 32'h0);
    idle(5'd31, 5'd0);
    expect_("bgezal0_r31", S_RD1, 32'h00003010);
    apply(1'b1, regimm(5'h11), 32'h00005558, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0);
    expect_("bgezal1_wew", S_WEW, 32'h1);
    idle(5'd31, 5'd0);
    expect_("bgezal1_r31", S_RD1, 32'h00005558);
    apply(1'b1, rtype(6'h09, 5'd7), 32'h0000600C, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(5'd7, 5'd0);
    expect_("jalr_r7", S_RD1, 32'h0000600C);

    apply(1'b1, rtype(6'h0B, 5'd9), 32'h0, 32'h55, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    expect_("movn0_wew", S_WEW, 32'h0);
    idle(5'd9, 5'd0);
    expect_("movn0_r9", S_RD1, 32'h0);
    apply(1'b1, rtype(6'h0B, 5'd9), 32'h0, 32'h55, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
    idle(5'd9, 5'd0);
    expect_("movn1_r9", S_RD1, 32'h55);

    apply(1'b1, rtype(6'h21, 5'd4), 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 5'd4, 5'd4);
    expect_("byp_rd1", S_RD1, 32'hA5A5A5A5);
    expect_("byp_rd2", S_RD2, 32'hA5A5A5A5);
    expect_("nobyp_old", S_RD1B, 32'h0);
    idle(5'd4, 5'd0);
    expect_("nobyp_new", S_RD1B, 32'hA5A5A5A5);

    // Counter: 10 retires among 3 bubbles, then run the 4-bit instance past its top.
    apply(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 13; i++) begin
      apply(1'b1, (i % 4 == 3) ? 32'h0 : BEQ, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    end
    idle(5'd0, 5'd0);
    expect_("cnt10", S_CNT, 32'd10);
    expect_("cnt10B", S_CNTB, 32'd10);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, BEQ, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    end
    idle(5'd0, 5'd0);
    expect_("cnt15B", S_CNTB, 32'd15);
    apply(1'b1, BEQ, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    expect_("cnt_wrapB", S_CNTB, 32'd0);
    expect_("cnt16", S_CNT, 32'd16);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
